// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and constants for the fifo drain arbiter.
package fifo_drain_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 6;
  localparam int unsigned NUM_FIFO   = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned DEST_MSB   = DATA_WIDTH - 1;
  localparam int unsigned DEST_LSB   = DATA_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  // Word popped last cycle whose data is arriving from the source fifo now.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] src;
  } inflight_t;

  function automatic logic [NUM_FIFO-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_FIFO'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Source-bank / destination-bank signal bundle for the drain arbiter.
interface fifo_drain_arbiter_if;
  import fifo_drain_arbiter_pkg::*;

  logic [NUM_FIFO-1:0]            Fifo_Empty;
  logic [NUM_FIFO*DATA_WIDTH-1:0] Fifo_Data_in;
  logic [NUM_FIFO-1:0]            Pausa_in;
  logic [NUM_FIFO-1:0]            Fifo_Full_in;
  logic [NUM_FIFO-1:0]            pop;
  logic [NUM_FIFO-1:0]            push;
  logic [DATA_WIDTH-1:0]          Data_out;
  logic                           Idle;
  logic                           Error_Arb;

  modport master (
    input  Fifo_Empty, Fifo_Data_in, Pausa_in, Fifo_Full_in,
    output pop, push, Data_out, Idle, Error_Arb
  );

  modport slave (
    output Fifo_Empty, Fifo_Data_in, Pausa_in, Fifo_Full_in,
    input  pop, push, Data_out, Idle, Error_Arb
  );
endinterface

// File: rtl/fifo_drain_arbiter_rr_grant.sv
// Request vector to single grant. RR_ARB_EN: round-robin from ptr; otherwise
// fixed priority with fifo 0 highest.
module fifo_drain_arbiter_rr_grant
  import fifo_drain_arbiter_pkg::*;
(
`ifdef RR_ARB_EN
  input  logic [IDX_W-1:0]    ptr,
`endif
  input  logic [NUM_FIFO-1:0] req,
  output logic                grant_v,
  output logic [IDX_W-1:0]    grant_idx
);

  // Scan from lowest priority to highest so the last hit wins.
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
`ifdef RR_ARB_EN
    for (int k = NUM_FIFO - 1; k >= 0; k--) begin
      if (req[IDX_W'(ptr + IDX_W'(k))]) begin
        grant_v   = 1'b1;
        grant_idx = IDX_W'(ptr + IDX_W'(k));
      end
    end
`else
    for (int k = NUM_FIFO - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_v   = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains a bank of source fifos one word per cycle and routes each word to the
// destination fifo named by its top two bits. Macro RR_ARB_EN selects round-robin.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fifo_drain_arbiter_if.master bus
);

  state_e                state;
  state_e                state_next;
  inflight_t             infl_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  idle_q;

  logic                  grant_v;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_req_c;
  logic                  pausa_c;
  logic                  pop_en_c;
  logic                  push_v_c;
  logic                  drop_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic [1:0]            dest_c;

  logic [NUM_FIFO-1:0]   pop_c;
  logic [NUM_FIFO-1:0]   push_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic                  err_c;

  assign any_req_c = ~&bus.Fifo_Empty;
  assign pausa_c   = |bus.Pausa_in;
  assign word_c    = bus.Fifo_Data_in[DATA_WIDTH*infl_q.src +: DATA_WIDTH];
  assign dest_c    = word_c[DEST_MSB:DEST_LSB];

  // Any almost-full stalls every pop; the spare slot absorbs the in-flight word.
  assign pop_en_c = ~reset & grant_v & ~pausa_c &
                    ((state == ST_IDLE) || (state == ST_ACTIVE));
  assign push_v_c = ~reset & infl_q.valid & ~bus.Fifo_Full_in[dest_c];
  assign drop_c   = ~reset & infl_q.valid &  bus.Fifo_Full_in[dest_c];

`ifdef RR_ARB_EN
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset)         ptr_q <= '0;
    else if (pop_en_c) ptr_q <= IDX_W'(grant_idx + 1'b1);
  end

  fifo_drain_arbiter_rr_grant u_grant (
    .ptr       (ptr_q),
    .req       (~bus.Fifo_Empty),
    .grant_v   (grant_v),
    .grant_idx (grant_idx)
  );
`else
  fifo_drain_arbiter_rr_grant u_grant (
    .req       (~bus.Fifo_Empty),
    .grant_v   (grant_v),
    .grant_idx (grant_idx)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_IDLE;
      ST_IDLE:   if (pop_en_c) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!any_req_c && !infl_q.valid) state_next = ST_IDLE;
      default:   state_next = ST_INIT;
    endcase
  end

  always_comb begin
    pop_c  = '0;
    push_c = '0;
    data_c = hold_q;
    err_c  = drop_c;
    if (pop_en_c) pop_c = onehot(grant_idx);
    if (push_v_c) begin
      push_c = onehot(dest_c);
      data_c = word_c;
    end
  end

  // In-flight tracking, last-pushed word and registered Idle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      infl_q <= '0;
      hold_q <= '0;
      idle_q <= 1'b0;
    end else begin
      infl_q.valid <= pop_en_c;
      infl_q.src   <= grant_idx;
      if (push_v_c) hold_q <= word_c;
      idle_q <= (state_next == ST_IDLE);
    end
  end

  assign bus.pop       = pop_c;
  assign bus.push      = push_c;
  assign bus.Data_out  = data_c;
  assign bus.Error_Arb = err_c;
  assign bus.Idle      = idle_q;

endmodule
